// File: rtl/hc_chain_pkg.sv
// Shared definitions for the 74HC164 chain driver and the behavioural chain models.
package hc_chain_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT_LO,
        SHIFT_HI,
        DONE
    } hc_state_e;

    // Clock-to-output delay of the behavioural 164 models, in simulation time units.
    localparam int HC_TPD = 1;

endpackage

// File: rtl/hc164_driver.sv
// Loads a word over valid/ready and shifts it MSB-first into a daisy chain of 74HC164s,
// generating the chain's shift clock, serial data and clear line.
module hc164_driver
    import hc_chain_pkg::*;
#(
    parameter int NBYTES  = 1,
    parameter int CLK_DIV = 2
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [8*NBYTES-1:0] s_data,
    input  logic                clr_req,
    output logic                busy,
    output logic                done,
    output logic                sr_clk,
    output logic                sr_d,
    output logic                sr_clr_n
);

    localparam int W  = 8 * NBYTES;
    localparam int PW = $clog2(CLK_DIV + 1);
    localparam int BW = (W > 1) ? $clog2(W) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(W - 1);

    hc_state_e     state, state_next;
    logic [PW-1:0] phase_cnt, phase_next;
    logic [BW-1:0] bit_cnt, bit_next;
    logic [W-1:0]  shift_buf, buf_next;
    logic          done_next, sr_clk_next, sr_clr_n_next;
    logic          phase_end;

    assign s_ready   = (state == IDLE);
    assign busy      = !s_ready;
    assign phase_end = (phase_cnt == '0);

    // The buffer MSB is the serial data flop: it only moves when a new low phase starts,
    // and after the last bit it simply holds until the next load.
    assign sr_d = shift_buf[W-1];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state     <= IDLE;
            phase_cnt <= '0;
            bit_cnt   <= '0;
            shift_buf <= '0;
            done      <= 1'b0;
            sr_clk    <= 1'b0;
            sr_clr_n  <= 1'b0;
        end else begin
            state     <= state_next;
            phase_cnt <= phase_next;
            bit_cnt   <= bit_next;
            shift_buf <= buf_next;
            done      <= done_next;
            sr_clk    <= sr_clk_next;
            sr_clr_n  <= sr_clr_n_next;
        end
    end

    always_comb begin
        state_next    = state;
        phase_next    = phase_cnt;
        bit_next      = bit_cnt;
        buf_next      = shift_buf;
        done_next     = 1'b0;
        sr_clk_next   = sr_clk;
        sr_clr_n_next = 1'b1;

        case (state)
            IDLE: begin
                sr_clk_next = 1'b0;
                if (clr_req) begin
                    state_next    = CLEAR;
                    phase_next    = PHASE_LAST;
                    sr_clr_n_next = 1'b0;
                end else if (s_valid) begin
                    state_next = SHIFT_LO;
                    phase_next = PHASE_LAST;
                    bit_next   = BIT_LAST;
                    buf_next   = s_data;
                end
            end
            CLEAR: begin
                if (phase_end) begin
                    state_next = IDLE;
                end else begin
                    phase_next    = phase_cnt - PW'(1);
                    sr_clr_n_next = 1'b0;
                end
            end
            SHIFT_LO: begin
                if (phase_end) begin
                    state_next  = SHIFT_HI;
                    phase_next  = PHASE_LAST;
                    sr_clk_next = 1'b1;
                end else begin
                    phase_next = phase_cnt - PW'(1);
                end
            end
            SHIFT_HI: begin
                if (phase_end) begin
                    sr_clk_next = 1'b0;
                    if (bit_cnt == '0) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = SHIFT_LO;
                        phase_next = PHASE_LAST;
                        bit_next   = bit_cnt - BW'(1);
                        buf_next   = {shift_buf[W-2:0], 1'b0};
                    end
                end else begin
                    phase_next = phase_cnt - PW'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_hc164_driver.sv
// Drives two hc164_driver configurations into behavioural 164 chains and checks serial
// timing, chain contents, clears and resets against frame-level expectations.
module tb_hc164_driver;
    import hc_chain_pkg::*;

    logic        clk = 1'b0;
    logic        clr_n;
    logic [1:0]  s_valid;
    logic [1:0]  clr_req;
    logic [15:0] s_data_a;
    logic [7:0]  s_data_b;
    wire  [1:0]  s_ready, busy, done, sr_clk, sr_d, sr_clr_n;
    logic [7:0]  dev_a0, dev_a1, dev_b0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    string       phase_name = "reset";

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance 0: two devices, two clk cycles per sr_clk phase.
    hc164_driver #(.NBYTES(2), .CLK_DIV(2)) dut_a (
        .clk(clk), .clr_n(clr_n), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
        .s_data(s_data_a), .clr_req(clr_req[0]), .busy(busy[0]), .done(done[0]),
        .sr_clk(sr_clk[0]), .sr_d(sr_d[0]), .sr_clr_n(sr_clr_n[0])
    );

    // Instance 1: single device at the fastest shift rate.
    hc164_driver #(.NBYTES(1), .CLK_DIV(1)) dut_b (
        .clk(clk), .clr_n(clr_n), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
        .s_data(s_data_b), .clr_req(clr_req[1]), .busy(busy[1]), .done(done[1]),
        .sr_clk(sr_clk[1]), .sr_d(sr_d[1]), .sr_clr_n(sr_clr_n[1])
    );

    // 74HC164 models: async clear, shift on sr_clk rise, q[7] feeds the next device.
    always @(posedge sr_clk[0] or negedge sr_clr_n[0]) begin
        if (!sr_clr_n[0]) begin
            dev_a0 <= #HC_TPD 8'h00;
            dev_a1 <= #HC_TPD 8'h00;
        end else begin
            dev_a0 <= #HC_TPD {dev_a0[6:0], sr_d[0]};
            dev_a1 <= #HC_TPD {dev_a1[6:0], dev_a0[7]};
        end
    end

    always @(posedge sr_clk[1] or negedge sr_clr_n[1]) begin
        if (!sr_clr_n[1]) dev_b0 <= #HC_TPD 8'h00;
        else              dev_b0 <= #HC_TPD {dev_b0[6:0], sr_d[1]};
    end

    function automatic logic [15:0] chainOf(input int d);
        return (d != 0) ? {8'h00, dev_b0} : {dev_a1, dev_a0};
    endfunction

    task automatic setData(input int d, input logic [15:0] word);
        if (d != 0) s_data_b = word[7:0];
        else        s_data_a = word;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s (%s): observed 0x%0h, expected 0x%0h", tag, phase_name, observed, expected);
        end
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s (%s): observed %b, expected %b", tag, phase_name, observed, expected);
        end
    endtask

    // Offers a word, waits for acceptance, then follows the whole frame. Expected edge times,
    // bit order and chain contents come straight from the frame rules, not from DUT state.
    task automatic applyStimulus(input int d, input logic [15:0] word, input bit clr_mid,
                                 input bit keep_valid, input logic [15:0] next_word, output int t);
        int w, cd, n, nrise, done_at, rise_err, ready_err, clrn_err, dstab_err;
        logic [15:0] got, mask;
        logic prev_clk, prev_d;
        bit pulsed;
        w    = (d != 0) ? 8 : 16;
        cd   = (d != 0) ? 1 : 2;
        mask = (d != 0) ? 16'h00FF : 16'hFFFF;
        s_valid[d] = 1'b1;
        setData(d, word);
        n = 0;
        while (s_ready[d] !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        t = cyc;
        checkBit("accept_ready", s_ready[d], 1'b1);
        prev_clk = sr_clk[d];
        prev_d   = sr_d[d];
        @(posedge clk);
        #2;
        if (keep_valid) setData(d, next_word);
        else begin
            s_valid[d] = 1'b0;
            setData(d, 16'($urandom));
        end
        nrise = 0; done_at = -1; rise_err = 0; ready_err = 0; clrn_err = 0; dstab_err = 0;
        got = '0; pulsed = 1'b0;
        for (int i = 0; i < 40 * w * cd; i++) begin
            @(negedge clk);
            if (clr_mid) begin
                clr_req[d] = (nrise == w / 2) && !pulsed;
                if (clr_req[d]) pulsed = 1'b1;
            end
            if (sr_clk[d] === 1'b1 && prev_clk === 1'b0) begin
                if (cyc != t + 1 + cd + 2 * nrise * cd) rise_err++;
                got = {got[14:0], sr_d[d]};
                nrise++;
            end
            if (sr_d[d] !== prev_d && !(cyc == t + 1 || (prev_clk === 1'b1 && sr_clk[d] === 1'b0)))
                dstab_err++;
            if (s_ready[d] !== 1'b0 || busy[d] !== 1'b1) ready_err++;
            if (sr_clr_n[d] !== 1'b1) clrn_err++;
            prev_clk = sr_clk[d];
            prev_d   = sr_d[d];
            if (done[d] === 1'b1) begin
                done_at = cyc;
                break;
            end
        end
        clr_req[d] = 1'b0;
        checkOutput("done_cycle", done_at, t + 1 + 2 * w * cd);
        checkOutput("rise_count", nrise, w);
        checkOutput("rise_timing_errs", rise_err, 0);
        checkOutput("serial_bits", int'(got & mask), int'(word & mask));
        checkOutput("busy_in_frame_errs", ready_err, 0);
        checkOutput("clr_n_in_frame_errs", clrn_err, 0);
        checkOutput("sr_d_stability_errs", dstab_err, 0);
        @(negedge clk);
        checkBit("done_one_cycle", done[d], 1'b0);
        checkBit("ready_after_done", s_ready[d], 1'b1);
        checkOutput("chain_contents", int'(chainOf(d)), int'(word & mask));
    endtask

    // Requests a clear (optionally with s_valid in the same cycle) and follows it to IDLE.
    task automatic runClear(input int d, input bit with_valid, input logic [15:0] word,
                            output int ready_at);
        int cd, t, first_low, lows, done_seen, clk_seen;
        logic [15:0] chain_low;
        cd = (d != 0) ? 1 : 2;
        checkBit("clear_start_idle", s_ready[d], 1'b1);
        clr_req[d] = 1'b1;
        if (with_valid) begin
            s_valid[d] = 1'b1;
            setData(d, word);
        end
        t = cyc;
        @(posedge clk);
        #2;
        clr_req[d] = 1'b0;
        first_low = -1; lows = 0; ready_at = -1; done_seen = 0; clk_seen = 0; chain_low = '1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done[d] === 1'b1) done_seen++;
            if (sr_clk[d] !== 1'b0) clk_seen++;
            if (sr_clr_n[d] === 1'b0) begin
                lows++;
                if (first_low < 0) first_low = cyc;
                chain_low = chainOf(d);
            end
            if (s_ready[d] === 1'b1) begin
                ready_at = cyc;
                break;
            end
        end
        checkOutput("clear_first_low", first_low, t + 1);
        checkOutput("clear_low_cycles", lows, cd);
        checkOutput("clear_ready_cycle", ready_at, t + cd + 1);
        checkOutput("clear_no_done", done_seen, 0);
        checkOutput("clear_sr_clk_low", clk_seen, 0);
        checkOutput("clear_chain_zero", int'(chain_low), 0);
    endtask

    task automatic checkResetValues();
        for (int d = 0; d < 2; d++) begin
            checkBit("rst_s_ready", s_ready[d], 1'b1);
            checkBit("rst_busy", busy[d], 1'b0);
            checkBit("rst_done", done[d], 1'b0);
            checkBit("rst_sr_clk", sr_clk[d], 1'b0);
            checkBit("rst_sr_d", sr_d[d], 1'b0);
            checkBit("rst_sr_clr_n", sr_clr_n[d], 1'b0);
        end
    endtask

    task automatic releaseReset();
        @(posedge clk);
        #2;
        clr_n = 1'b1;
        @(negedge clk);
        checkBit("release_before_edge", sr_clr_n[0], 1'b0);
        @(negedge clk);
        checkBit("release_clr_n_a", sr_clr_n[0], 1'b1);
        checkBit("release_clr_n_b", sr_clr_n[1], 1'b1);
    endtask

    initial begin
        int t1, t2, r, d, nrise, w, cd;
        logic [15:0] wa, wb;
        logic prev;
        clr_n = 1'b1;
        s_valid = '0;
        clr_req = '0;
        s_data_a = '0;
        s_data_b = '0;
        #1;
        clr_n = 1'b0;
        repeat (3) @(negedge clk);
        checkResetValues();
        releaseReset();

        phase_name = "A55A then held 0F0F";
        applyStimulus(0, 16'hA55A, 1'b0, 1'b1, 16'h0F0F, t1);
        applyStimulus(0, 16'h0F0F, 1'b0, 1'b0, 16'h0000, t2);
        checkOutput("back_to_back_accept", t2, t1 + 66);

        phase_name = "clear with valid";
        applyStimulus(0, 16'hA55A, 1'b0, 1'b0, 16'h0000, t1);
        runClear(0, 1'b1, 16'h3C96, r);
        applyStimulus(0, 16'h3C96, 1'b0, 1'b0, 16'h0000, t2);
        checkOutput("accept_after_clear", t2, r);

        phase_name = "reset mid-frame";
        s_valid[0] = 1'b1;
        setData(0, 16'hF731);
        for (int i = 0; i < 400 && s_ready[0] !== 1'b1; i++) @(negedge clk);
        @(posedge clk);
        #2;
        s_valid[0] = 1'b0;
        nrise = 0;
        prev = sr_clk[0];
        for (int i = 0; i < 400 && nrise < 5; i++) begin
            @(negedge clk);
            if (sr_clk[0] === 1'b1 && prev === 1'b0) nrise++;
            prev = sr_clk[0];
        end
        checkOutput("abort_edges_seen", nrise, 5);
        #1;
        clr_n = 1'b0;
        #1;
        checkResetValues();
        #(HC_TPD + 1);
        checkOutput("abort_chain_zero", int'(chainOf(0)), 0);
        @(negedge clk);
        checkBit("abort_held_clr_n", sr_clr_n[0], 1'b0);
        checkBit("abort_held_ready", s_ready[0], 1'b1);
        releaseReset();
        applyStimulus(0, 16'($urandom), 1'b0, 1'b0, 16'h0000, t1);

        phase_name = "single device 01";
        applyStimulus(1, 16'h0001, 1'b0, 1'b0, 16'h0000, t1);

        phase_name = "clr_req mid-frame";
        applyStimulus(0, 16'($urandom), 1'b1, 1'b0, 16'h0000, t1);
        applyStimulus(1, 16'($urandom), 1'b1, 1'b0, 16'h0000, t1);

        phase_name = "random";
        for (int i = 0; i < 10; i++) begin
            d  = int'($urandom_range(0, 1));
            w  = (d != 0) ? 8 : 16;
            cd = (d != 0) ? 1 : 2;
            wa = 16'($urandom);
            wb = 16'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if ($urandom_range(0, 3) == 0) runClear(d, 1'b0, 16'h0000, r);
            if ($urandom_range(0, 1) == 1) begin
                applyStimulus(d, wa, 1'($urandom_range(0, 1)), 1'b1, wb, t1);
                applyStimulus(d, wb, 1'b0, 1'b0, 16'h0000, t2);
                checkOutput("random_back_to_back", t2, t1 + 2 * w * cd + 2);
            end else begin
                applyStimulus(d, wa, 1'($urandom_range(0, 1)), 1'b0, 16'h0000, t1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached in %s", phase_name);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
